// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed driver for a 4-digit, common-anode
// 7-segment display.
//
// Each digit owns a slot of DIV clk cycles. The first BLANK cycles of every
// slot keep all anodes dark so the segments can settle on the new digit's
// pattern before it lights (no ghosting). Segment, decimal-point and anode
// outputs are all registered, so they change together on the same edge.
//
// FSM: IDLE (scan frozen, dark) -> BLANK (slot start, dark) -> SHOW (lit).
// Dropping enable returns to IDLE from anywhere. The prescaler and digit
// index are frozen while in IDLE. When enable rises again the slot restarts
// from its beginning on the same digit.
//
// Optional build macro DISPLAY_SCANNER_LZB_EN enables leading-zero blanking.
// Digits are scanned upward, 0 -> 3, so the higher digits of a number have
// not been seen yet when a lower digit is shown. The design therefore
// remembers, for digits 3 and 2, whether their value was zero at their last
// slot. A digit k in 1..3 is dark when its own value is zero and every
// higher digit was remembered as zero. Digit 0 is never blanked, and the
// decimal point is not affected.
//
// state_dbg exposes the FSM state for observation only.

module display_scanner #(
   parameter int DIV   = 50000,
   parameter int BLANK = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic [3:0] num,
   input  logic       decimal,
   output logic [1:0] digit,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [3:0] anode_n,
   output logic       frame_done,
   output logic [1:0] state_dbg
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_SHOW  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    digit_q, digit_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    anode_q, anode_d;
   logic          frame_done_q, frame_done_d;
   logic          slot_end;
   logic [6:0]    seg_raw;

   // Last cycle of a running slot: the digit index advances on this edge.
   assign slot_end = enable && (state_q == ST_SHOW) && (cnt_q == CNT_LAST);

   // Scan sequencing: prescaler, digit index, FSM and frame pulse.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      digit_d      = digit_q;
      frame_done_d = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_BLANK;
               cnt_d   = '0;
            end
            ST_BLANK: begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
               if (slot_end) begin
                  cnt_d        = '0;
                  state_d      = ST_BLANK;
                  digit_d      = digit_q + 2'd1;
                  frame_done_d = (digit_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Active-low hex decode of the currently selected digit's value.
   always_comb begin
      seg_raw = 7'h7F;
      case (num)
         4'h0: seg_raw = 7'h40;
         4'h1: seg_raw = 7'h79;
         4'h2: seg_raw = 7'h24;
         4'h3: seg_raw = 7'h30;
         4'h4: seg_raw = 7'h19;
         4'h5: seg_raw = 7'h12;
         4'h6: seg_raw = 7'h02;
         4'h7: seg_raw = 7'h78;
         4'h8: seg_raw = 7'h00;
         4'h9: seg_raw = 7'h10;
         4'hA: seg_raw = 7'h08;
         4'hB: seg_raw = 7'h03;
         4'hC: seg_raw = 7'h46;
         4'hD: seg_raw = 7'h21;
         4'hE: seg_raw = 7'h06;
         4'hF: seg_raw = 7'h0E;
         default: seg_raw = 7'h7F;
      endcase
   end

`ifdef DISPLAY_SCANNER_LZB_EN
   logic [3:2] zero_hist_q, zero_hist_d;
   logic       num_zero;
   logic       lzb_dark;

   // Leading-zero decision plus the per-digit zero memory for digits 3 and 2.
   always_comb begin
      num_zero    = (num == 4'h0);
      zero_hist_d = zero_hist_q;
      lzb_dark    = 1'b0;
      case (digit_q)
         2'd3:    lzb_dark = num_zero;
         2'd2:    lzb_dark = num_zero && zero_hist_q[3];
         2'd1:    lzb_dark = num_zero && zero_hist_q[3] && zero_hist_q[2];
         default: lzb_dark = 1'b0;
      endcase
      if (slot_end && (digit_q == 2'd3)) zero_hist_d[3] = num_zero;
      if (slot_end && (digit_q == 2'd2)) zero_hist_d[2] = num_zero;
      seg_d = lzb_dark ? 7'h7F : seg_raw;
   end

   // Zero memory starts cleared so nothing is dark before digits 2/3 are seen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) zero_hist_q <= 2'b00;
      else          zero_hist_q <= zero_hist_d;
   end
`else
   // Without blanking every digit shows its decoded value.
   always_comb begin
      seg_d = seg_raw;
   end
`endif

   // Display outputs: anodes follow the next state so they light only in SHOW,
   // and use the current digit so they line up with the registered segments.
   always_comb begin
      dp_d    = ~decimal;
      anode_d = (state_d == ST_SHOW) ? ~(4'b0001 << digit_q) : 4'hF;
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         digit_q      <= 2'd0;
         seg_q        <= 7'h7F;
         dp_q         <= 1'b1;
         anode_q      <= 4'hF;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         anode_q      <= anode_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign digit      = digit_q;
   assign seg_n      = seg_q;
   assign dp_n       = dp_q;
   assign anode_n    = anode_q;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with DIV=4, BLANK=1. The reference model tracks
// time since the scan (re)started and derives slot position and digit by
// plain division; the display mux is modelled by value/decimal tables
// indexed by the digit output.

module tb_display_scanner;

   localparam int DIV   = 4;
   localparam int BLANK = 1;

   logic       clk;
   logic       reset_n;
   logic       enable;
   logic [3:0] num;
   logic       decimal;
   logic [1:0] digit;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [3:0] anode_n;
   logic       frame_done;
   logic [1:0] state_dbg;

   logic [3:0] vals [4];
   logic       dps  [4];

   int checks;
   int errors;

   // model state
   bit         m_run;
   int         m_n;
   int         m_d0;
   int         m_digit;
   bit         m_warm;
   bit         seg_known;
   logic [6:0] e_seg;
   logic       e_dp;
   logic [3:0] e_anode;
   logic       e_fd;

   display_scanner #(.DIV(DIV), .BLANK(BLANK)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .num        (num),
      .decimal    (decimal),
      .digit      (digit),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .anode_n    (anode_n),
      .frame_done (frame_done),
      .state_dbg  (state_dbg)
   );

   // display mux model
   assign num     = vals[digit];
   assign decimal = dps[digit];

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // never more than one anode low
   always @(negedge clk) begin
      checks++;
      if ($countones(~anode_n) > 1) begin
         errors++;
         $display("FAIL anode_onehot: anode_n=%b has more than one low bit", anode_n);
      end
   end

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // digit k is dark when it and all higher digits are zero (k > 0)
   function automatic bit lzb_dark(input int k);
`ifdef DISPLAY_SCANNER_LZB_EN
      if (k == 0) return 1'b0;
      for (int j = k; j < 4; j++) if (vals[j] != 4'h0) return 1'b0;
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      m_run   = 1'b0;
      m_n     = 0;
      m_d0    = 0;
      m_digit = 0;
      m_warm  = 1'b0;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
      e_anode = 4'hF;
      e_fd    = 1'b0;
   endtask

   // One clock: drive enable, predict the outputs launched by the edge, compare.
   task automatic tick(input logic en);
      int pos;
      int nd;
      enable = en;
      @(posedge clk);
      seg_known = 1'b1;
`ifdef DISPLAY_SCANNER_LZB_EN
      if (!m_warm && (m_digit == 1 || m_digit == 2)) seg_known = 1'b0;
`endif
      e_seg = lzb_dark(m_digit) ? 7'h7F : hex7(vals[m_digit]);
      e_dp  = ~dps[m_digit];
      if (!en) begin
         m_run   = 1'b0;
         e_anode = 4'hF;
         e_fd    = 1'b0;
      end else if (!m_run) begin
         m_run   = 1'b1;
         m_n     = 0;
         m_d0    = m_digit;
         e_anode = 4'hF;
         e_fd    = 1'b0;
      end else begin
         m_n++;
         nd  = (m_d0 + m_n / DIV) % 4;
         pos = m_n % DIV;
         if (pos == 0 && m_digit == 3) m_warm = 1'b1;
         e_fd    = (pos == 0 && nd == 0);
         e_anode = (pos < BLANK) ? 4'hF : ~(4'b0001 << nd);
         m_digit = nd;
      end
      @(negedge clk);
      checks++;
      if (digit !== 2'(m_digit)) begin
         errors++;
         $display("FAIL digit: got %0d expected %0d", digit, m_digit);
      end
      checks++;
      if (anode_n !== e_anode) begin
         errors++;
         $display("FAIL anode_n: got %b expected %b", anode_n, e_anode);
      end
      checks++;
      if (frame_done !== e_fd) begin
         errors++;
         $display("FAIL frame_done: got %b expected %b", frame_done, e_fd);
      end
      checks++;
      if (dp_n !== e_dp) begin
         errors++;
         $display("FAIL dp_n: got %b expected %b", dp_n, e_dp);
      end
      if (seg_known) begin
         checks++;
         if (seg_n !== e_seg) begin
            errors++;
            $display("FAIL seg_n: got %h expected %h (digit %0d)", seg_n, e_seg, m_digit);
         end
      end
   endtask

   // Assert reset between edges, check outputs before any edge, then release.
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      checks++;
      if (anode_n !== 4'hF) begin
         errors++;
         $display("FAIL %s anode_n: got %b expected 1111", tag, anode_n);
      end
      checks++;
      if (seg_n !== 7'h7F) begin
         errors++;
         $display("FAIL %s seg_n: got %h expected 7f", tag, seg_n);
      end
      checks++;
      if (digit !== 2'd0) begin
         errors++;
         $display("FAIL %s digit: got %0d expected 0", tag, digit);
      end
      checks++;
      if (dp_n !== 1'b1 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL %s dp/frame: got %b/%b expected 1/0", tag, dp_n, frame_done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      enable  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vals[i] = 4'(i);
         dps[i]  = 1'b0;
      end
      reset_n = 1'b1;
      #1;
      do_reset("reset");
   endtask

   // Free-running scan, num equals digit index.
   task automatic test_scan();
      int fd_count;
      for (int i = 0; i < 4; i++) begin
         vals[i] = 4'(i);
         dps[i]  = 1'($urandom_range(0, 1));
      end
      do_reset("scan_reset");
      fd_count = 0;
      for (int t = 0; t < 48; t++) begin
         tick(1'b1);
         if (frame_done === 1'b1) fd_count++;
         if (e_anode == 4'b1110) begin
            checks++;
            if (seg_n !== 7'h40) begin
               errors++;
               $display("FAIL seg_digit0: got %h expected 40", seg_n);
            end
         end
         if (e_anode == 4'b0111) begin
            checks++;
            if (seg_n !== 7'h30) begin
               errors++;
               $display("FAIL seg_digit3: got %h expected 30", seg_n);
            end
         end
      end
      checks++;
      if (fd_count != 2) begin
         errors++;
         $display("FAIL frame_count: got %0d expected 2", fd_count);
      end
   endtask

   // Enable low mid-slot on digit 2, and enable low on the last cycle of digit 3.
   task automatic test_enable_drop();
      int guard;
      int lit;
      guard = 0;
      while (!(m_run && m_digit == 2 && (m_n % DIV) == 2) && guard < 64) begin
         tick(1'b1);
         guard++;
      end
      checks++;
      if (guard >= 64) begin
         errors++;
         $display("FAIL drop_setup: no digit 2 cnt 2 within %0d cycles", guard);
      end
      for (int t = 0; t < 5; t++) begin
         tick(1'b0);
         checks++;
         if (anode_n !== 4'hF || digit !== 2'd2 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL drop_hold: got anode %b digit %0d fd %b expected 1111 2 0",
                     anode_n, digit, frame_done);
         end
      end
      lit = 0;
      for (int t = 0; t < DIV; t++) begin
         tick(1'b1);
         if (anode_n === 4'b1011) lit++;
      end
      checks++;
      if (lit != DIV - BLANK) begin
         errors++;
         $display("FAIL drop_resume: digit 2 lit %0d cycles expected %0d", lit, DIV - BLANK);
      end
      guard = 0;
      while (!(m_run && m_digit == 3 && (m_n % DIV) == DIV - 1) && guard < 64) begin
         tick(1'b1);
         guard++;
      end
      tick(1'b0);
      checks++;
      if (digit !== 2'd3 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL enable_wins: got digit %0d fd %b expected 3 0", digit, frame_done);
      end
      for (int t = 0; t < 8; t++) tick(1'b1);
   endtask

   // Asynchronous reset while digit 3 is lit.
   task automatic test_reset_mid();
      int guard;
      guard = 0;
      while (!(m_run && m_digit == 3 && (m_n % DIV) >= BLANK) && guard < 64) begin
         tick(1'b1);
         guard++;
      end
      checks++;
      if (anode_n !== 4'b0111) begin
         errors++;
         $display("FAIL reset_mid_setup: got anode %b expected 0111", anode_n);
      end
      #2;
      do_reset("reset_mid");
      tick(1'b1);
      checks++;
      if (digit !== 2'd0 || anode_n !== 4'hF) begin
         errors++;
         $display("FAIL reset_mid_restart: got digit %0d anode %b expected 0 1111", digit, anode_n);
      end
      for (int t = 0; t < 20; t++) tick(1'b1);
   endtask

   // Random values, decimal points and enable gaps.
   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            vals[i] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) vals[i] = 4'h0;
            dps[i]  = 1'($urandom_range(0, 1));
         end
         do_reset("random_reset");
         for (int t = 0; t < 150; t++) tick(1'($urandom_range(0, 9) != 0));
      end
   endtask

   // Digits 3..0 = 0,0,5,0.
   task automatic test_lzb();
      logic [6:0] want [4];
`ifdef DISPLAY_SCANNER_LZB_EN
      want[3] = 7'h7F; want[2] = 7'h7F;
`else
      want[3] = 7'h40; want[2] = 7'h40;
`endif
      want[1] = 7'h12; want[0] = 7'h40;
      vals[3] = 4'h0; vals[2] = 4'h0; vals[1] = 4'h5; vals[0] = 4'h0;
      for (int i = 0; i < 4; i++) dps[i] = 1'b1;
      do_reset("lzb_reset");
      for (int t = 0; t < 48; t++) begin
         tick(1'b1);
         if (m_warm && e_anode != 4'hF) begin
            checks++;
            if (seg_n !== want[m_digit]) begin
               errors++;
               $display("FAIL lzb_digit%0d: got %h expected %h", m_digit, seg_n, want[m_digit]);
            end
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      enable  = 1'b0;
      reset_n = 1'b1;
      model_reset();
      test_reset();
      test_scan();
      test_enable_drop();
      test_reset_mid();
      test_random();
      test_lzb();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
